// File: rtl/vga_pattern_gen_if.sv
// Video pattern generator bus: pattern configuration in, aligned video stream out.
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 3
);
    logic [1:0]            mode;
    logic [COLOR_BITS-1:0] fg_color;
    logic [COLOR_BITS-1:0] bg_color;
    logic [COLOR_BITS-1:0] pixel;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    logic                  frame_start;

    // The generator drives the video stream and reads the configuration.
    modport master (
        input  mode, fg_color, bg_color,
        output pixel, hsync, vsync, de, frame_start
    );

    // The consumer / controller side: supplies configuration, watches video.
    modport slave (
        output mode, fg_color, bg_color,
        input  pixel, hsync, vsync, de, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with a four-pattern test engine
// (solid, colour bars, checker, bouncing box). Every video output is
// registered one clock after the counters that produced it.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_BITS = 3,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_pattern_gen_if.master    vif,
    output logic [XW-1:0]        counter_x,
    output logic [YW-1:0]        counter_y
);

    localparam int BAR_W  = H_ACTIVE >> COLOR_BITS;
    localparam int BAR_PW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0]         X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]         Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW:0]           H_ACT_W  = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0]           HS_BEG   = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0]           HS_END   = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0]           V_ACT_W  = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0]           VS_BEG   = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0]           VS_END   = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW:0]           BOX_XW   = (XW+1)'(BOX_SIZE);
    localparam logic [YW:0]           BOX_YW   = (YW+1)'(BOX_SIZE);
    localparam logic [XW-1:0]         BX_MAX   = XW'(H_ACTIVE - BOX_SIZE);
    localparam logic [YW-1:0]         BY_MAX   = YW'(V_ACTIVE - BOX_SIZE);
    localparam logic [BAR_PW-1:0]     BAR_END  = BAR_PW'(BAR_W - 1);
    localparam logic [COLOR_BITS-1:0] BAR_LAST = '1;

    // Raster position, latched pattern and box state
    logic [XW-1:0]         cx_q, cx_d;
    logic [YW-1:0]         cy_q, cy_d;
    logic [BAR_PW-1:0]     bar_pos_q, bar_pos_d;
    logic [COLOR_BITS-1:0] bar_idx_q, bar_idx_d;
    logic [1:0]            mode_q, mode_d;
    logic [XW-1:0]         bx_q, bx_d;
    logic [YW-1:0]         by_q, by_d;
    logic                  dx_neg_q, dx_neg_d;
    logic                  dy_neg_q, dy_neg_d;

    // Registered video outputs
    logic [COLOR_BITS-1:0] pixel_q, pixel_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  de_q, de_d;
    logic                  frame_start_q, frame_start_d;

    logic          last_x, last_y, frame_end;
    logic [XW:0]   cx_w;
    logic [YW:0]   cy_w;
    logic          active, in_box;

    assign last_x    = (cx_q == X_LAST);
    assign last_y    = (cy_q == Y_LAST);
    assign frame_end = last_x && last_y;
    assign cx_w      = {1'b0, cx_q};
    assign cy_w      = {1'b0, cy_q};
    assign active    = (cx_w < H_ACT_W) && (cy_w < V_ACT_W);
    assign in_box    = (cx_w >= {1'b0, bx_q}) && (cx_w < ({1'b0, bx_q} + BOX_XW)) &&
                       (cy_w >= {1'b0, by_q}) && (cy_w < ({1'b0, by_q} + BOX_YW));

    // Raster scan: x wraps every line, y steps on each x wrap and wraps per frame
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (last_x) begin
            cx_d = '0;
            cy_d = last_y ? '0 : cy_q + YW'(1);
        end else begin
            cx_d = cx_q + XW'(1);
        end
    end

    // Bar index tracks x in BAR_W steps without a divider; saturates so leftover pixels keep the last bar
    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (last_x) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (bar_pos_q == BAR_END) begin
            bar_pos_d = '0;
            if (bar_idx_q != BAR_LAST) begin
                bar_idx_d = bar_idx_q + COLOR_BITS'(1);
            end
        end else begin
            bar_pos_d = bar_pos_q + BAR_PW'(1);
        end
    end

    // On the last clock of a frame: move the box (decided by the outgoing mode) and latch the new mode
    always_comb begin
        mode_d   = mode_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        if (frame_end) begin
            mode_d = vif.mode;
            if (mode_q == 2'd3) begin
                if (!dx_neg_q) begin
                    if (bx_q == BX_MAX) begin
                        dx_neg_d = 1'b1;
                        bx_d     = bx_q - XW'(1);
                    end else begin
                        bx_d = bx_q + XW'(1);
                    end
                end else begin
                    if (bx_q == '0) begin
                        dx_neg_d = 1'b0;
                        bx_d     = bx_q + XW'(1);
                    end else begin
                        bx_d = bx_q - XW'(1);
                    end
                end
                if (!dy_neg_q) begin
                    if (by_q == BY_MAX) begin
                        dy_neg_d = 1'b1;
                        by_d     = by_q - YW'(1);
                    end else begin
                        by_d = by_q + YW'(1);
                    end
                end else begin
                    if (by_q == '0) begin
                        dy_neg_d = 1'b0;
                        by_d     = by_q + YW'(1);
                    end else begin
                        by_d = by_q - YW'(1);
                    end
                end
            end
        end
    end

    // Decode the current raster position into the next set of video outputs
    always_comb begin
        pixel_d = '0;
        if (active) begin
            case (mode_q)
                2'd0:    pixel_d = vif.fg_color;
                2'd1:    pixel_d = bar_idx_q;
                2'd2:    pixel_d = (cx_q[CHECK_LOG2] ^ cy_q[CHECK_LOG2]) ? vif.fg_color : vif.bg_color;
                default: pixel_d = in_box ? vif.fg_color : vif.bg_color;
            endcase
        end
        hsync_d       = ((cx_w >= HS_BEG) && (cx_w < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((cy_w >= VS_BEG) && (cy_w < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        de_d          = active;
        frame_start_d = (cx_q == '0) && (cy_q == '0);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q          <= '0;
            cy_q          <= '0;
            bar_pos_q     <= '0;
            bar_idx_q     <= '0;
            mode_q        <= 2'd0;
            bx_q          <= '0;
            by_q          <= '0;
            dx_neg_q      <= 1'b0;
            dy_neg_q      <= 1'b0;
            pixel_q       <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            bar_pos_q     <= bar_pos_d;
            bar_idx_q     <= bar_idx_d;
            mode_q        <= mode_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            dx_neg_q      <= dx_neg_d;
            dy_neg_q      <= dy_neg_d;
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.pixel       = pixel_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.frame_start = frame_start_q;
    assign counter_x       = cx_q;
    assign counter_y       = cy_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing generator with a built-in test-pattern engine.
- Replaces the fixed 640x480 sync generator and the hard-wired solid colour in the top level.
- Produces registered, mutually aligned sync, data-enable and pixel outputs from one pixel clock.
- Four runtime-selectable patterns; mode changes are applied only on frame boundaries, so there is no tearing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync
- COLOR_BITS, 3, pixel width; also sets colour-bar count to 2**COLOR_BITS
- CHECK_LOG2, 5, checker square edge = 2**CHECK_LOG2 pixels
- BOX_SIZE, 32, bouncing-box edge in pixels; must be less than V_ACTIVE

Ports:
- clk  input  1  pixel clock (25 MHz for default timing)
- rst  input  1  asynchronous, active-high reset
- mode  input  2  pattern select: 0 solid, 1 bars, 2 checker, 3 box
- fg_color  input  COLOR_BITS  foreground colour
- bg_color  input  COLOR_BITS  background colour
- pixel  output  COLOR_BITS  registered pixel value
- hsync  output  1  registered horizontal sync
- vsync  output  1  registered vertical sync
- de  output  1  registered display enable
- frame_start  output  1  one-cycle pulse, coincident with output of pixel (0,0)
- counter_x  output  log2(H_TOTAL)  internal horizontal counter, unregistered
- counter_y  output  log2(V_TOTAL)  internal vertical counter, unregistered

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Horizontal counter:
  - Counts 0..H_TOTAL-1 and wraps to 0.
  - The vertical counter increments on each horizontal wrap, counts 0..V_TOTAL-1 and wraps to 0.
- Region decode:
  - Active region: x < H_ACTIVE and y < V_ACTIVE.
  - hsync is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, on whole lines (changes at x = 0).
- Latency:
  - pixel, hsync, vsync, de and frame_start reflect the counter values of the previous cycle (exactly 1 clock).
  - All five outputs are aligned with each other.
- Blanking: outside the active region, pixel = 0 regardless of mode.
- Reset (asynchronous, active-high):
  - Counters = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - de = 0, pixel = 0, frame_start = 0.
  - Latched mode = 0.
  - Box position bx = 0, by = 0; direction dx = +1, dy = +1.
  - After rst deasserts, the first clock edge registers pixel (0,0) state, so frame_start = 1 in that following cycle.
- Mode latch:
  - mode is sampled only on the last clock of a frame (x = H_TOTAL-1, y = V_TOTAL-1).
  - The new mode applies from pixel (0,0) of the next frame.
  - Mid-frame changes are ignored until then.
  - fg_color and bg_color are not latched; they are used live.
- Mode 0 (solid): pixel = fg_color.
- Mode 1 (colour bars):
  - BAR_W = H_ACTIVE >> COLOR_BITS.
  - pixel = bar index, 0 .. 2**COLOR_BITS-1.
  - Implemented with a bar counter that increments every BAR_W pixels and resets at x = 0. No divider.
  - Leftover pixels (when H_ACTIVE is not a multiple) take the last index.
- Mode 2 (checker): pixel = fg_color when bit 0 of ((x>>CHECK_LOG2) XOR (y>>CHECK_LOG2)) is 1, else bg_color.
- Mode 3 (bouncing box):
  - pixel = fg_color when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, else bg_color.
- Box position update:
  - Happens on the frame's last clock, and only when the latched mode is 3; otherwise the position is frozen.
  - Per axis: if dx = +1 and bx = H_ACTIVE-BOX_SIZE, dx becomes -1 and bx decrements.
  - Per axis: if dx = -1 and bx = 0, dx becomes +1 and bx increments.
  - Otherwise bx moves by dx. The same rules apply to by/dy against V_ACTIVE.
  - The box never exceeds the active area, and it never stays at an edge for two frames.
- Simultaneous events: a mode latch and a box update on the same clock both use the pre-latch mode for the update decision.

Test Plan:
- Default params, mode 0, fg = 3'b001:
  - Per line: hsync low for exactly 96 clocks, starting 656 clocks after de rises.
  - vsync low for exactly 2×800 clocks per 525-line frame.
  - de high 640×480 = 307200 clocks per frame; pixel = 1 only while de = 1.
- Mode 1:
  - Line 0 pixel values: x = 0 → 0, x = 79 → 0, x = 80 → 1, x = 639 → 7.
  - pixel = 0 at x = 640..799.
- Mode 2, fg = 7, bg = 0:
  - (0,0) → 0, (32,0) → 7, (32,32) → 0, (31,33) → 7.
- Mode switches 0 → 2 at line 100:
  - Rest of that frame stays solid.
  - Next frame's first pixel is checker; frame_start pulses exactly once per 420000 clocks.
- Mode 3 for 700 frames:
  - bx reaches 608 at frame 608, then reads 607 next frame.
  - by reaches 448 then reverses.
  - Box pixel count per frame is always 1024.
- Reset asserted mid-line, mid-frame:
  - All outputs take reset values immediately, without waiting for a clock.
  - After deassertion, frame_start appears one clock later and sync periods match the first test.
